// File: rtl/raster_pkg.sv
// Shared types and helpers for the edge-function rasterizer.
package raster_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BBOX,
        S_SETUP,
        S_SCAN,
        S_DRAIN,
        S_DONE
    } state_t;

    function automatic int unsigned edge_width(input int unsigned coord_w);
        return 2 * coord_w + 2;
    endfunction

    // Inclusive coverage: negative reference area wants all E <= 0, positive wants all E >= 0.
    function automatic logic covered(input logic [2:0] neg, input logic [2:0] zero,
                                     input logic area_neg);
        if (area_neg)
            return &(neg | zero);
        else
            return ~|neg;
    endfunction

endpackage

// File: rtl/edge_eval.sv
// One incremental edge function: holds A/B, the row-start value and the current value.
module edge_eval
    import raster_pkg::*;
#(
    parameter int unsigned EW = edge_width(16)
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 load,
    input  logic                 step_x,
    input  logic                 step_y,
    input  logic signed [EW-1:0] a_in,
    input  logic signed [EW-1:0] b_in,
    input  logic signed [EW-1:0] e_in,
    output logic signed [EW-1:0] e
);

    logic signed [EW-1:0] a_q;
    logic signed [EW-1:0] b_q;
    logic signed [EW-1:0] row_q;
    logic signed [EW-1:0] cur_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            a_q   <= '0;
            b_q   <= '0;
            row_q <= '0;
            cur_q <= '0;
        end else if (load) begin
            a_q   <= a_in;
            b_q   <= b_in;
            row_q <= e_in;
            cur_q <= e_in;
        end else if (step_y) begin
            row_q <= row_q + b_q;
            cur_q <= row_q + b_q;
        end else if (step_x) begin
            cur_q <= cur_q + a_q;
        end
    end

    assign e = cur_q;

endmodule

// File: rtl/edge_rasterizer_hs.sv
// Self-sequencing edge-function triangle rasterizer with valid/ready input and pixel stream.
module edge_rasterizer_hs
    import raster_pkg::*;
#(
    parameter int unsigned COORD_W    = 16,
    parameter int unsigned DEPTH_W    = 2,
    parameter int unsigned COLOR_W    = 16,
    parameter int unsigned SCREEN_W   = 640,
    parameter int unsigned SCREEN_H   = 480,
    parameter int unsigned DEPTH_MODE = 0
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [COORD_W-1:0]     in_v0_x,
    input  logic [COORD_W-1:0]     in_v0_y,
    input  logic [COORD_W-1:0]     in_v1_x,
    input  logic [COORD_W-1:0]     in_v1_y,
    input  logic [COORD_W-1:0]     in_v2_x,
    input  logic [COORD_W-1:0]     in_v2_y,
    input  logic [DEPTH_W-1:0]     in_v0_depth,
    input  logic [DEPTH_W-1:0]     in_v1_depth,
    input  logic [DEPTH_W-1:0]     in_v2_depth,
    input  logic [COLOR_W-1:0]     in_color,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [COORD_W-1:0]     out_pixel_x,
    output logic [COORD_W-1:0]     out_pixel_y,
    output logic [DEPTH_W-1:0]     out_pixel_depth,
    output logic [COLOR_W-1:0]     out_pixel_color,
    output logic                   out_done,
    output logic [2*COORD_W-1:0]   out_pix_count
);

    localparam int unsigned EW = edge_width(COORD_W);
    localparam logic [COORD_W-1:0] X_LIM = COORD_W'(SCREEN_W - 1);
    localparam logic [COORD_W-1:0] Y_LIM = COORD_W'(SCREEN_H - 1);

    state_t               state;
    logic [COORD_W-1:0]   vx [3];
    logic [COORD_W-1:0]   vy [3];
    logic [DEPTH_W-1:0]   vd [3];
    logic [COLOR_W-1:0]   color_q;
    logic [COORD_W-1:0]   xmin, xmax, ymin, ymax;
    logic [COORD_W-1:0]   x_cur, y_cur;
    logic [DEPTH_W-1:0]   depth_q;
    logic                 area_neg;
    logic [2*COORD_W-1:0] pix_cnt;

    function automatic logic [COORD_W-1:0] min3(input logic [COORD_W-1:0] a,
                                                input logic [COORD_W-1:0] b,
                                                input logic [COORD_W-1:0] c);
        logic [COORD_W-1:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic logic [COORD_W-1:0] max3(input logic [COORD_W-1:0] a,
                                                input logic [COORD_W-1:0] b,
                                                input logic [COORD_W-1:0] c);
        logic [COORD_W-1:0] m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    function automatic logic [COORD_W-1:0] clamp(input logic [COORD_W-1:0] v,
                                                 input logic [COORD_W-1:0] lim);
        return (v > lim) ? lim : v;
    endfunction

    // Minimum is clamped as well so an off-screen box still keeps min <= max.
    logic [COORD_W-1:0] bb_xmin, bb_xmax, bb_ymin, bb_ymax;
    logic [DEPTH_W-1:0] bb_depth;
    logic [DEPTH_W-1:0] dmin;

    always_comb begin
        bb_xmin = clamp(min3(vx[0], vx[1], vx[2]), X_LIM);
        bb_xmax = clamp(max3(vx[0], vx[1], vx[2]), X_LIM);
        bb_ymin = clamp(min3(vy[0], vy[1], vy[2]), Y_LIM);
        bb_ymax = clamp(max3(vy[0], vy[1], vy[2]), Y_LIM);
        dmin = vd[0];
        if (vd[1] < dmin) dmin = vd[1];
        if (vd[2] < dmin) dmin = vd[2];
        bb_depth = (DEPTH_MODE == 1) ? dmin : vd[0];
    end

    logic                 advance;
    logic                 load_e, step_x, step_y;
    logic [2:0]           e_neg, e_zero;
    logic signed [EW-1:0] e_init [3];
    logic signed [EW-1:0] area;
    logic                 cov;

    assign advance = !out_valid || out_ready;
    assign load_e  = (state == S_SETUP);
    assign step_x  = (state == S_SCAN) && advance && (x_cur != xmax);
    assign step_y  = (state == S_SCAN) && advance && (x_cur == xmax) && (y_cur != ymax);

    for (genvar gi = 0; gi < 3; gi++) begin : g_edge
        localparam int NB = (gi + 1) % 3;
        logic signed [EW-1:0] xa, ya, xb, yb, xs, ys;
        logic signed [EW-1:0] a_c, b_c, e_cur;

        assign xa  = EW'(vx[gi]);
        assign ya  = EW'(vy[gi]);
        assign xb  = EW'(vx[NB]);
        assign yb  = EW'(vy[NB]);
        assign xs  = EW'(xmin);
        assign ys  = EW'(ymin);
        assign a_c = yb - ya;
        assign b_c = xa - xb;
        assign e_init[gi] = a_c * (xs - xa) + b_c * (ys - ya);

        edge_eval #(.EW(EW)) u_edge (
            .clock   (clock),
            .reset_n (reset_n),
            .load    (load_e),
            .step_x  (step_x),
            .step_y  (step_y),
            .a_in    (a_c),
            .b_in    (b_c),
            .e_in    (e_init[gi]),
            .e       (e_cur)
        );

        assign e_neg[gi]  = e_cur[EW-1];
        assign e_zero[gi] = (e_cur == '0);
    end

    // Edge-function sum is position independent: twice the signed triangle area.
    assign area = e_init[0] + e_init[1] + e_init[2];
    assign cov  = covered(e_neg, e_zero, area_neg);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state           <= S_IDLE;
            in_ready        <= 1'b1;
            out_valid       <= 1'b0;
            out_done        <= 1'b0;
            out_pix_count   <= '0;
            out_pixel_x     <= '0;
            out_pixel_y     <= '0;
            out_pixel_depth <= '0;
            out_pixel_color <= '0;
            pix_cnt         <= '0;
        end else begin
            out_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        vx[0]    <= in_v0_x;
                        vy[0]    <= in_v0_y;
                        vx[1]    <= in_v1_x;
                        vy[1]    <= in_v1_y;
                        vx[2]    <= in_v2_x;
                        vy[2]    <= in_v2_y;
                        vd[0]    <= in_v0_depth;
                        vd[1]    <= in_v1_depth;
                        vd[2]    <= in_v2_depth;
                        color_q  <= in_color;
                        in_ready <= 1'b0;
                        state    <= S_BBOX;
                    end
                end
                S_BBOX: begin
                    xmin    <= bb_xmin;
                    xmax    <= bb_xmax;
                    ymin    <= bb_ymin;
                    ymax    <= bb_ymax;
                    depth_q <= bb_depth;
                    state   <= S_SETUP;
                end
                S_SETUP: begin
                    area_neg <= area[EW-1];
                    x_cur    <= xmin;
                    y_cur    <= ymin;
                    pix_cnt  <= '0;
                    if (area == '0) begin
                        out_done      <= 1'b1;
                        out_pix_count <= '0;
                        state         <= S_DONE;
                    end else begin
                        state <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (advance) begin
                        if (cov) begin
                            out_valid       <= 1'b1;
                            out_pixel_x     <= x_cur;
                            out_pixel_y     <= y_cur;
                            out_pixel_depth <= depth_q;
                            out_pixel_color <= color_q;
                            pix_cnt         <= pix_cnt + 1'b1;
                        end else begin
                            out_valid <= 1'b0;
                        end
                        if (x_cur == xmax) begin
                            x_cur <= xmin;
                            if (y_cur == ymax)
                                state <= S_DRAIN;
                            else
                                y_cur <= y_cur + 1'b1;
                        end else begin
                            x_cur <= x_cur + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (advance) begin
                        out_valid     <= 1'b0;
                        out_done      <= 1'b1;
                        out_pix_count <= pix_cnt;
                        state         <= S_DONE;
                    end
                end
                S_DONE: begin
                    in_ready <= 1'b1;
                    state    <= S_IDLE;
                end
                default: begin
                    in_ready <= 1'b1;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_edge_rasterizer_hs.sv
// Self-checking bench for edge_rasterizer_hs against a point-in-triangle reference model.
module tb_edge_rasterizer_hs;

    localparam int CW = 16;
    localparam int DW = 2;
    localparam int KW = 16;
    localparam int SW = 640;
    localparam int SH = 480;
    localparam int DM = 1;

    logic            clock = 1'b0;
    logic            reset_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [CW-1:0]   in_v0_x = '0, in_v0_y = '0, in_v1_x = '0, in_v1_y = '0, in_v2_x = '0, in_v2_y = '0;
    logic [DW-1:0]   in_v0_depth = '0, in_v1_depth = '0, in_v2_depth = '0;
    logic [KW-1:0]   in_color = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [CW-1:0]   out_pixel_x, out_pixel_y;
    logic [DW-1:0]   out_pixel_depth;
    logic [KW-1:0]   out_pixel_color;
    logic            out_done;
    logic [2*CW-1:0] out_pix_count;

    always #5 clock = ~clock;

    edge_rasterizer_hs #(
        .COORD_W(CW), .DEPTH_W(DW), .COLOR_W(KW),
        .SCREEN_W(SW), .SCREEN_H(SH), .DEPTH_MODE(DM)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_v0_x(in_v0_x), .in_v0_y(in_v0_y),
        .in_v1_x(in_v1_x), .in_v1_y(in_v1_y),
        .in_v2_x(in_v2_x), .in_v2_y(in_v2_y),
        .in_v0_depth(in_v0_depth), .in_v1_depth(in_v1_depth), .in_v2_depth(in_v2_depth),
        .in_color(in_color),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pixel_x(out_pixel_x), .out_pixel_y(out_pixel_y),
        .out_pixel_depth(out_pixel_depth), .out_pixel_color(out_pixel_color),
        .out_done(out_done), .out_pix_count(out_pix_count)
    );

    int errors = 0;
    int checks = 0;

    int exp_x[$], exp_y[$];
    int exp_d, exp_c, exp_xlo, exp_ylo;
    bit exp_degen;
    int got_x[$], got_y[$], got_d[$];
    int hold_cycles, first_k, done_k;

    function automatic longint orient(longint ax, longint ay, longint bx, longint by,
                                      longint px, longint py);
        return (bx - ax) * (py - ay) - (by - ay) * (px - ax);
    endfunction

    function automatic int imin(int a, int b); return (a < b) ? a : b; endfunction
    function automatic int imax(int a, int b); return (a > b) ? a : b; endfunction

    // Every integer point inside or on the triangle, row-major within the clamped box.
    function automatic void build_model(int x0, int y0, int x1, int y1, int x2, int y2,
                                        int d0, int d1, int d2, int col);
        int xlo, xhi, ylo, yhi;
        longint a, w0, w1, w2;
        exp_x.delete();
        exp_y.delete();
        xlo = imin(imin(imin(x0, x1), x2), SW - 1);
        xhi = imin(imax(imax(x0, x1), x2), SW - 1);
        ylo = imin(imin(imin(y0, y1), y2), SH - 1);
        yhi = imin(imax(imax(y0, y1), y2), SH - 1);
        exp_xlo = xlo;
        exp_ylo = ylo;
        a = orient(x0, y0, x1, y1, x2, y2);
        exp_degen = (a == 0);
        if (!exp_degen) begin
            for (int y = ylo; y <= yhi; y++) begin
                for (int x = xlo; x <= xhi; x++) begin
                    w0 = orient(x0, y0, x1, y1, x, y);
                    w1 = orient(x1, y1, x2, y2, x, y);
                    w2 = orient(x2, y2, x0, y0, x, y);
                    if ((w0 >= 0 && w1 >= 0 && w2 >= 0) || (w0 <= 0 && w1 <= 0 && w2 <= 0)) begin
                        exp_x.push_back(x);
                        exp_y.push_back(y);
                    end
                end
            end
        end
        exp_d = (DM == 1) ? imin(imin(d0, d1), d2) : d0;
        exp_c = col;
    endfunction

    task automatic drive_tri(input int x0, input int y0, input int x1, input int y1,
                             input int x2, input int y2, input int d0, input int d1,
                             input int d2, input int col);
        int wait_n;
        wait_n = 0;
        while (in_ready !== 1'b1 && wait_n < 50) begin
            @(posedge clock); #1;
            wait_n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL in_ready_wait: got %0b want 1", in_ready);
        end
        in_v0_x = CW'(x0); in_v0_y = CW'(y0);
        in_v1_x = CW'(x1); in_v1_y = CW'(y1);
        in_v2_x = CW'(x2); in_v2_y = CW'(y2);
        in_v0_depth = DW'(d0); in_v1_depth = DW'(d1); in_v2_depth = DW'(d2);
        in_color = KW'(col);
        in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
    endtask

    // mode 0: always ready, 1: random ready, 2: stall 5 cycles on the third pixel
    task automatic run_triangle(input int x0, input int y0, input int x1, input int y1,
                                input int x2, input int y2, input int d0, input int d1,
                                input int d2, input int col, input int mode);
        int k, n_exp, stall_left, ex, ey;
        bit done_seen, stalled_once, prev_hold;
        logic [CW-1:0] sx, sy;
        logic [DW-1:0] sd;
        logic [KW-1:0] sc;
        build_model(x0, y0, x1, y1, x2, y2, d0, d1, d2, col);
        n_exp = exp_x.size();
        got_x.delete(); got_y.delete(); got_d.delete();
        hold_cycles = 0; first_k = -1; done_k = -1;
        drive_tri(x0, y0, x1, y1, x2, y2, d0, d1, d2, col);
        k = 1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL busy_in_ready: got %0b want 0", in_ready);
        end
        out_ready = 1'b1;
        done_seen = 0; stalled_once = 0; prev_hold = 0; stall_left = 0;
        sx = '0; sy = '0; sd = '0; sc = '0;
        while (!done_seen && k < 5000) begin
            if (prev_hold) begin
                checks++;
                if (out_valid !== 1'b1 || out_pixel_x !== sx || out_pixel_y !== sy ||
                    out_pixel_depth !== sd || out_pixel_color !== sc) begin
                    errors++;
                    $display("FAIL hold_stable: got v=%0b (%0d,%0d) d=%0d c=%h want v=1 (%0d,%0d) d=%0d c=%h",
                             out_valid, out_pixel_x, out_pixel_y, out_pixel_depth, out_pixel_color,
                             sx, sy, sd, sc);
                end
            end
            if (out_done === 1'b1) begin
                done_seen = 1;
                done_k = k;
            end else begin
                if (out_valid === 1'b1 && first_k < 0) first_k = k;
                if (mode == 2 && out_valid === 1'b1 && got_x.size() == 2 && !stalled_once) begin
                    stalled_once = 1;
                    stall_left = 5;
                end
                if (stall_left > 0) begin
                    out_ready = 1'b0;
                    stall_left--;
                    if (out_valid === 1'b1) hold_cycles++;
                end else if (mode == 1) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                end else begin
                    out_ready = 1'b1;
                end
                if (out_valid === 1'b1 && out_ready) begin
                    got_x.push_back(int'(out_pixel_x));
                    got_y.push_back(int'(out_pixel_y));
                    got_d.push_back(int'(out_pixel_depth));
                    checks++;
                    if (exp_x.size() == 0) begin
                        errors++;
                        $display("FAIL extra_pixel: got (%0d,%0d) want none", out_pixel_x, out_pixel_y);
                    end else begin
                        ex = exp_x.pop_front();
                        ey = exp_y.pop_front();
                        if (int'(out_pixel_x) != ex || int'(out_pixel_y) != ey ||
                            int'(out_pixel_depth) != exp_d || int'(out_pixel_color) != exp_c) begin
                            errors++;
                            $display("FAIL pixel: got (%0d,%0d) d=%0d c=%h want (%0d,%0d) d=%0d c=%h",
                                     out_pixel_x, out_pixel_y, out_pixel_depth, out_pixel_color,
                                     ex, ey, exp_d, exp_c);
                        end
                    end
                end
                prev_hold = (out_valid === 1'b1) && !out_ready;
                sx = out_pixel_x; sy = out_pixel_y; sd = out_pixel_depth; sc = out_pixel_color;
                @(posedge clock); #1;
                k++;
            end
        end
        out_ready = 1'b1;
        checks++;
        if (!done_seen) begin
            errors++;
            $display("FAIL done_timeout: got no out_done want out_done within 5000 cycles");
        end else begin
            checks++;
            if (out_pix_count !== (2*CW)'(n_exp)) begin
                errors++;
                $display("FAIL pix_count: got %0d want %0d", out_pix_count, n_exp);
            end
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL valid_at_done: got %0b want 0", out_valid);
            end
            checks++;
            if (exp_x.size() != 0) begin
                errors++;
                $display("FAIL missing_pixels: got %0d outstanding want 0", exp_x.size());
            end
            if (exp_degen) begin
                checks++;
                if (done_k != 3 || first_k != -1) begin
                    errors++;
                    $display("FAIL degen_timing: got done_k=%0d first_k=%0d want 3 and -1", done_k, first_k);
                end
            end else if (n_exp > 0 && got_x.size() > 0 && got_x[0] == exp_xlo && got_y[0] == exp_ylo) begin
                checks++;
                if (first_k != 4) begin
                    errors++;
                    $display("FAIL first_latency: got %0d want 4", first_k);
                end
            end
            @(posedge clock); #1;
            checks++;
            if (out_done !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL after_done: got done=%0b ready=%0b want 0 1", out_done, in_ready);
            end
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_done !== 1'b0 || out_pix_count !== '0 ||
            out_pixel_x !== '0 || out_pixel_y !== '0 || out_pixel_depth !== '0 || out_pixel_color !== '0) begin
            errors++;
            $display("FAIL reset_state: got v=%0b r=%0b d=%0b cnt=%0d x=%0d y=%0d want 0 1 0 0 0 0",
                     out_valid, in_ready, out_done, out_pix_count, out_pixel_x, out_pixel_y);
        end
        reset_n = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic check_ten_order(input string name);
        int rx[10] = '{0, 1, 2, 3, 0, 1, 2, 0, 1, 0};
        int ry[10] = '{0, 0, 0, 0, 1, 1, 1, 2, 2, 3};
        bit ok;
        ok = (got_x.size() == 10);
        for (int i = 0; i < 10 && ok; i++)
            if (got_x[i] != rx[i] || got_y[i] != ry[i]) ok = 0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_order: got %0d pixels want the fixed 10-pixel row-major list", name, got_x.size());
        end
    endtask

    task automatic test_ccw;
        run_triangle(0, 0, 3, 0, 0, 3, 2, 1, 3, 16'hFF00, 0);
        check_ten_order("ccw");
    endtask

    task automatic test_cw;
        run_triangle(0, 0, 0, 3, 3, 0, 1, 2, 3, 16'h1234, 0);
        check_ten_order("cw");
    endtask

    task automatic test_degenerate;
        run_triangle(0, 0, 1, 1, 2, 2, 0, 0, 0, 16'hABCD, 0);
        checks++;
        if (got_x.size() != 0) begin
            errors++;
            $display("FAIL degen_pixels: got %0d want 0", got_x.size());
        end
    endtask

    task automatic test_back_pressure;
        run_triangle(0, 0, 3, 0, 0, 3, 2, 2, 2, 16'hFF00, 2);
        check_ten_order("stall");
        checks++;
        if (hold_cycles != 5 || got_x.size() < 3 || got_x[2] != 2 || got_y[2] != 0) begin
            errors++;
            $display("FAIL stall_hold: got hold=%0d want 5 cycles on pixel (2,0)", hold_cycles);
        end
    endtask

    task automatic test_clamp_depth;
        int mx;
        bit dok;
        run_triangle(632, 2, 700, 6, 634, 12, 3, 1, 2, 16'h0F0F, 0);
        mx = 0;
        dok = 1;
        foreach (got_x[i]) begin
            if (got_x[i] > mx) mx = got_x[i];
            if (got_d[i] != 1) dok = 0;
        end
        checks++;
        if (got_x.size() == 0 || mx > SW - 1) begin
            errors++;
            $display("FAIL clamp_x: got max x %0d over %0d pixels want <= %0d", mx, got_x.size(), SW - 1);
        end
        checks++;
        if (!dok) begin
            errors++;
            $display("FAIL min_depth: got non-1 depth want 1");
        end
    endtask

    task automatic test_reset_mid_scan;
        bit bad;
        drive_tri(0, 0, 7, 0, 0, 7, 1, 1, 1, 16'h5555);
        out_ready = 1'b1;
        repeat (7) begin
            @(posedge clock); #1;
        end
        reset_n = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_done !== 1'b0 || out_pix_count !== '0 ||
            out_pixel_x !== '0 || out_pixel_y !== '0) begin
            errors++;
            $display("FAIL mid_reset: got v=%0b r=%0b d=%0b cnt=%0d x=%0d y=%0d want 0 1 0 0 0 0",
                     out_valid, in_ready, out_done, out_pix_count, out_pixel_x, out_pixel_y);
        end
        bad = 0;
        repeat (12) begin
            @(posedge clock); #1;
            if (out_done !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) bad = 1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL post_reset_idle: got activity after reset want idle");
        end
        run_triangle(0, 0, 3, 0, 0, 3, 3, 0, 2, 16'hFF00, 0);
        check_ten_order("after_reset");
    endtask

    task automatic test_random;
        for (int n = 0; n < 14; n++) begin
            run_triangle(int'($urandom_range(0, 10)), int'($urandom_range(0, 10)),
                         int'($urandom_range(0, 10)), int'($urandom_range(0, 10)),
                         int'($urandom_range(0, 10)), int'($urandom_range(0, 10)),
                         int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                         int'($urandom_range(0, 3)), int'($urandom_range(0, 65535)), 1);
        end
    endtask

    initial begin
        test_reset();
        test_ccw();
        test_cw();
        test_degenerate();
        test_back_pressure();
        test_clamp_depth();
        test_reset_mid_scan();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
